// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: captures ALU operands A, B and opcode O from switches, one value per button press.
// Define ALU_SEQ_DEBOUNCE_EN to insert a counter-based debouncer ahead of the press edge detector.
module alu_input_sequencer #(
    parameter int N_BITS          = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] SW,
    input  logic              BTN,
    input  logic [N_BITS-1:0] Z,
    output logic [N_BITS-1:0] A,
    output logic [N_BITS-1:0] B,
    output logic [N_BITS-1:0] O,
    output logic [N_BITS-1:0] R,
    output logic              VALID,
    output logic [1:0]        STATE
);
    typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, LOAD_OP = 2'd2, SHOW = 2'd3} state_t;

    state_t            r_state, w_next;
    logic              r_sync1, r_sync2, r_hist;
    logic              w_level, w_press;
    logic [N_BITS-1:0] r_a, r_b, r_o, r_r;
    logic              r_valid;

    // Button history resets high so a press held through reset is ignored until re-pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] r_db_cnt;
    logic          r_db_level;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
        end else if (r_sync2 == r_db_level) begin
            r_db_cnt   <= '0;
        end else if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_db_level <= r_sync2;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt   <= r_db_cnt + 1'b1;
        end
    end
    assign w_level = r_db_level;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_hist <= 1'b1;
        else       r_hist <= w_level;
    end

    assign w_press = w_level & ~r_hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= LOAD_A;
        else       r_state <= w_next;
    end

    // States are numbered in load order, so SHOW wraps back to LOAD_A.
    always_comb begin
        w_next = r_state;
        w_next = w_press ? state_t'(r_state + 2'd1) : r_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_o     <= '0;
            r_r     <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_press && r_state == LOAD_A)  r_a <= SW;
            if (w_press && r_state == LOAD_B)  r_b <= SW;
            if (w_press && r_state == LOAD_OP) r_o <= SW;
            if (r_state == SHOW) begin
                if (w_press) begin
                    r_valid <= 1'b0;
                end else begin
                    r_r     <= Z;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign A     = r_a;
    assign B     = r_b;
    assign O     = r_o;
    assign R     = r_r;
    assign VALID = r_valid;
    assign STATE = r_state;
endmodule

// File: tb/tb_alu_input_sequencer.sv
// tb_alu_input_sequencer: scoreboard bench for alu_input_sequencer with an adder standing in for the ALU.
module tb_alu_input_sequencer;
    localparam int DB = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [1:0] st;
        logic [7:0] a, b, o, r;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] SW = 8'h00;
    logic       BTN = 1'b0;
    logic [7:0] Z, A, B, O, R;
    logic       VALID;
    logic [1:0] STATE;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] m_st;
    logic [7:0] m_a, m_b, m_o, m_r;
    logic       m_v;

    alu_input_sequencer #(.N_BITS(8), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .SW(SW), .BTN(BTN), .Z(Z),
        .A(A), .B(B), .O(O), .R(R), .VALID(VALID), .STATE(STATE)
    );

    assign Z = A + B;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        q.push_back('{m_st, m_a, m_b, m_o, m_r, m_v});
    endtask

    task automatic check_dut(input string tag);
        exp_t e;
        chk({tag, "_queue"}, q.size(), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_state"}, STATE, e.st);
            chk({tag, "_a"}, A, e.a);
            chk({tag, "_b"}, B, e.b);
            chk({tag, "_o"}, O, e.o);
            chk({tag, "_r"}, R, e.r);
            chk({tag, "_valid"}, VALID, e.v);
        end
    endtask

    task automatic model_reset();
        {m_st, m_a, m_b, m_o, m_r, m_v} = '0;
        q.delete();
    endtask

    task automatic model_press(input logic [7:0] sw);
        case (m_st)
            2'd0: m_a = sw;
            2'd1: m_b = sw;
            2'd2: m_o = sw;
            default: m_v = 1'b0;
        endcase
        m_st = m_st + 2'd1;
    endtask

    task automatic do_press(input string tag, input logic [7:0] sw, input int hold);
        logic [1:0] old;
        @(negedge clk);
        SW  = sw;
        BTN = 1'b1;
        old = m_st;
        model_press(sw);
        push_exp();
        repeat (LAT) @(negedge clk);
        chk({tag, "_pre"}, STATE, old);
        @(negedge clk);
        check_dut(tag);
        if (m_st == 2'd3) begin
            @(negedge clk);
            m_r = m_a + m_b;
            m_v = 1'b1;
            push_exp();
            check_dut({tag, "_show"});
        end
        repeat (hold) @(negedge clk);
        BTN = 1'b0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 model_reset();
        push_exp();
        check_dut("reset_async");
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 4) @(negedge clk);

        do_press("ld_a", 8'h0F, 2);
        do_press("ld_b", 8'h01, 2);
        do_press("ld_op", 8'h20, 2);
        SW = 8'hAA;
        repeat (10) @(negedge clk);
        push_exp();
        check_dut("show_hold");

        do_press("leave_show", 8'h77, 1);
        SW = 8'hAA;
        repeat (10) @(negedge clk);
        push_exp();
        check_dut("sw_nopress");

        do_press("held", 8'h33, 50);
        push_exp();
        check_dut("held_after");

        // Short pulse: filtered by the debouncer, a real press otherwise.
        @(negedge clk);
        SW  = 8'h5A;
        BTN = 1'b1;
`ifdef ALU_SEQ_DEBOUNCE_EN
        repeat (DB - 1) @(negedge clk);
`else
        @(negedge clk);
        model_press(8'h5A);
`endif
        BTN = 1'b0;
        push_exp();
        repeat (LAT + 4) @(negedge clk);
        check_dut("short_pulse");
`ifdef ALU_SEQ_DEBOUNCE_EN
        do_press("ld_b2", 8'h5A, 1);
`endif

        @(negedge clk);
        SW  = 8'h99;
        BTN = 1'b1;
        #2 reset = 1'b1;
        #1 model_reset();
        push_exp();
        check_dut("reset_loadop");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        push_exp();
        check_dut("held_thru_reset");
        BTN = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        push_exp();
        check_dut("release_after_reset");
        do_press("first_after_reset", 8'h55, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Sequential front end for the TP1 combinational ALU: captures operand A, operand B and opcode O from a switch bank, one value per debounced button press. Drives the ALU inputs and registers the ALU result Z for display. Sits between the board I/O (switches, push button, LEDs) and the ALU instance. It is the driving end of the ALU's A/B/O → Z interface.

## Interface
- N_BITS, 8, width of SW, A, B, O, Z, R
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a BTN level is accepted (used only with the debounce feature)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- SW  input  N_BITS  switch value to capture
- BTN  input  1  load push button, asynchronous to clk
- Z  input  N_BITS  combinational result from the ALU
- A  output  N_BITS  operand A to ALU
- B  output  N_BITS  operand B to ALU
- O  output  N_BITS  opcode to ALU
- R  output  N_BITS  registered result for LEDs
- VALID  output  1  R holds the result for the current A/B/O
- STATE  output  2  current FSM state (LOAD_A=0, LOAD_B=1, LOAD_OP=2, SHOW=3)

## Operation
- BTN path: 2-flop synchronizer, then the optional debouncer, then a rising-edge detector. The detector produces `press`, a single-cycle pulse per press.
- Synchronizer, debounced level and edge-detect history reset to 1. A button held through reset release produces no press until it is released and pressed again.
- FSM, one transition per `press`:
  - LOAD_A: on press, A<=SW, go to LOAD_B.
  - LOAD_B: on press, B<=SW, go to LOAD_OP.
  - LOAD_OP: on press, O<=SW, go to SHOW.
  - SHOW: every cycle R<=Z and VALID<=1. On press, VALID<=0, go to LOAD_A. A, B, O and R keep their values.
- No press: the state and all registers hold.
- VALID clears on leaving SHOW and stays 0 through LOAD_A, LOAD_B and LOAD_OP.
- SW is sampled only on the capture edge. SW changes at any other time have no effect.
- Arithmetic is done solely by the ALU. R is a plain copy of Z, with no width change.

## Timing
- Reset (asynchronous, takes effect immediately): A=B=O=R=0, VALID=0, STATE=LOAD_A.
- Without debounce: BTN first sampled high at edge k. `press` is high between edges k+1 and k+2. The capture and state change happen at edge k+2.
- With debounce: capture happens DEBOUNCE_CYCLES edges later than without it. A BTN glitch shorter than DEBOUNCE_CYCLES cycles produces no press.
- ALU result: O is loaded at edge e (entry to SHOW). R and VALID update at edge e+1. R keeps tracking Z every cycle while in SHOW.
- Each press is exactly one transition. There is no auto-repeat while BTN is held.
- Reset asserted mid-sequence: the in-progress load is abandoned and the block returns to the reset values. The first press after reset release loads A.

## Configuration
- ALU_SEQ_DEBOUNCE_EN defined: a counter-based debouncer sits between the synchronizer and the edge detector.
  - The debounced level changes only after the synchronized BTN has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the current level restarts the count.
- ALU_SEQ_DEBOUNCE_EN undefined: no debouncer. The edge detector takes the synchronizer output directly, DEBOUNCE_CYCLES is ignored, and capture latency is 2 edges.

## Test plan
- Reset: assert reset mid-cycle with BTN=0 → A=B=O=R=0x00, VALID=0, STATE=0 immediately, without waiting for a clock edge.
- Full ADD sequence: SW=0x0F press, SW=0x01 press, SW=0x20 press, with the ALU returning Z=A+B → A=0x0F, B=0x01, O=0x20. One edge after entering SHOW: R=0x10, VALID=1, STATE=3.
- SHOW then next press → STATE=0, VALID=0, A/B/O/R unchanged. Changing SW to 0xAA without a press leaves A=0x0F.
- Held BTN: hold for 50 cycles in LOAD_A with SW=0x33 → exactly one capture (A=0x33), STATE=1, no further advance.
- Debounce build: a BTN pulse of DEBOUNCE_CYCLES-1 cycles → no state change. A clean press captures at edge k+2+DEBOUNCE_CYCLES.
- Reset during LOAD_OP with BTN held high → reset values. No press is generated until BTN is released and pressed again, and that press loads A.
